// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared pipelined 8x8 multiplier.
// One operation in flight at a time; the product is held until its owner takes it.
module mult_arbiter #(
  parameter int unsigned LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_prod,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_prod,
  output logic        busy
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ptr;    // 0: req0 has priority on a tie, 1: req1
  logic             owner;
  logic             grant0_c;
  logic             grant1_c;

  // Grant is combinational so a waiting requester is accepted on the first IDLE edge.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (reset && (state == IDLE)) begin
      grant0_c = req0_valid && (!req1_valid || !ptr);
      grant1_c = req1_valid && (!req0_valid ||  ptr);
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_prod   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c || grant1_c) begin
            mul_a <= grant1_c ? OP_W'(req1_a) : OP_W'(req0_a);
            mul_b <= grant1_c ? OP_W'(req1_b) : OP_W'(req0_b);
            owner <= grant1_c;
            cnt   <= CNT_W'(LATENCY + 1);
            // Favour whichever requester was not just served.
            ptr   <= grant0_c;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rsp_prod   <= PROD_W'(mul_prod);
            cnt        <= '0;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
